fp_divider_arbiter: RTL and testbench

- Shares one pipelined fp_divider (fixed latency, one issue per cycle) between NUM_REQ requesters, such as the correlation-matrix translator and the LDL solver.
- Arbitration is round-robin, with optional ownership lock for burst issue.
- Tags each issued operation and routes the result back to the issuing requester exactly DIVIDER_LATENCY cycles later.
- Provides quiesce/idle handshakes so a top-level sequencer can drain the divider between phases.

---
 rtl/fp_divider_arbiter.sv | 157 +++++++++++++++
 tb/tb_fp_divider_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_divider_arbiter.sv
// Round-robin arbiter sharing one pipelined fp_divider between NUM_REQ requesters, with tag-based result routing.
// Define FP_DIV_ARB_CHECK_EN to build the sticky pipe/grant consistency checker that drives err.
module fp_divider_arbiter #(
   parameter int NUM_REQ         = 2,
   parameter int WIDTH           = 32,
   parameter int DIVIDER_LATENCY = 28
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ-1:0]         req_lock,
   input  logic [NUM_REQ*WIDTH-1:0]   req_a,
   input  logic [NUM_REQ*WIDTH-1:0]   req_b,
   output logic [NUM_REQ-1:0]         req_grant,
   output logic [NUM_REQ-1:0]         resp_valid,
   output logic [WIDTH-1:0]           resp_data,
   input  logic                       quiesce,
   output logic                       idle,
   output logic [WIDTH-1:0]           div_a,
   output logic [WIDTH-1:0]           div_b,
   output logic                       div_ready,
   input  logic [WIDTH-1:0]           div_o,
   input  logic                       div_valid,
   output logic                       err
);
   localparam int TAG_WIDTH = $clog2(NUM_REQ);
   localparam int CNT_WIDTH = $clog2(DIVIDER_LATENCY + 1);

   typedef enum logic [1:0] {ARB, LOCKED, DRAIN} state_t;
   typedef struct packed {
      logic                 valid;
      logic [TAG_WIDTH-1:0] tag;
   } pipe_entry_t;

   state_t               state_q, state_d;
   logic [TAG_WIDTH-1:0] rr_q, rr_d;
   logic [TAG_WIDTH-1:0] owner_q, owner_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   pipe_entry_t          pipe_q [DIVIDER_LATENCY];
   pipe_entry_t          pipe_d [DIVIDER_LATENCY];
   pipe_entry_t          pipe_out;
   logic                 grant_vld;
   logic [TAG_WIDTH-1:0] grant_idx;

   always_comb begin : arbitrate
      int idx;
      // NOTE: blocking assignments with every output defaulted first keep this block free of latches.
      state_d   = state_q;
      rr_d      = rr_q;
      owner_d   = owner_q;
      grant_vld = 1'b0;
      grant_idx = '0;
      idx       = 0;
      case (state_q)
         ARB: begin
            if (quiesce) begin
               state_d = DRAIN;
            end else begin
               for (int k = 0; k < NUM_REQ; k++) begin
                  idx = int'(rr_q) + k;
                  if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                  if (!grant_vld && req_valid[TAG_WIDTH'(idx)]) begin
                     grant_vld = 1'b1;
                     grant_idx = TAG_WIDTH'(idx);
                  end
               end
               if (grant_vld) begin
                  rr_d = (grant_idx == TAG_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + TAG_WIDTH'(1);
                  if (req_lock[grant_idx]) begin
                     state_d = LOCKED;
                     owner_d = grant_idx;
                  end
               end
            end
         end
         LOCKED: begin
            // Pointer stays at owner+1 from the locking grant, so ARB resumes just past the owner.
            if (quiesce) begin
               state_d = DRAIN;
            end else if (req_valid[owner_q] && req_lock[owner_q]) begin
               grant_vld = 1'b1;
               grant_idx = owner_q;
            end else begin
               state_d = ARB;
            end
         end
         DRAIN: begin
            if (!quiesce) state_d = ARB;
         end
         default: state_d = ARB;
      endcase
   end

   assign req_grant = grant_vld ? (NUM_REQ'(1) << grant_idx) : '0;
   assign div_ready = grant_vld;
   assign div_a     = req_a[int'(grant_idx)*WIDTH +: WIDTH];
   assign div_b     = req_b[int'(grant_idx)*WIDTH +: WIDTH];

   // Tag pipe mirrors the divider depth so each result meets the tag of the requester that issued it.
   assign pipe_out = pipe_q[DIVIDER_LATENCY-1];

   always_comb begin : tag_shift
      pipe_d[0] = {grant_vld, grant_idx};
      for (int i = 1; i < DIVIDER_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
   end

   always_comb begin : count_next
      cnt_d = cnt_q;
      if (grant_vld && !pipe_out.valid)      cnt_d = cnt_q + CNT_WIDTH'(1);
      else if (!grant_vld && pipe_out.valid) cnt_d = cnt_q - CNT_WIDTH'(1);
   end

   always_comb begin : route
      resp_valid = '0;
      for (int i = 0; i < NUM_REQ; i++)
         resp_valid[i] = div_valid & pipe_out.valid & (pipe_out.tag == TAG_WIDTH'(i));
   end

   assign resp_data = div_o;
   assign idle      = (cnt_q == '0) & ~grant_vld;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ARB;
         rr_q    <= '0;
         owner_q <= '0;
         cnt_q   <= '0;
         // NOTE: the tag pipe must be reset so results of squashed operations are never routed.
         for (int i = 0; i < DIVIDER_LATENCY; i++) pipe_q[i] <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         for (int i = 0; i < DIVIDER_LATENCY; i++) pipe_q[i] <= pipe_d[i];
      end
   end

`ifdef FP_DIV_ARB_CHECK_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q | (div_valid != pipe_out.valid)
                    | ((req_grant & (req_grant - NUM_REQ'(1))) != '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) err_q <= 1'b0;
      else      err_q <= err_d;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fp_divider_arbiter.sv
// Directed bench for fp_divider_arbiter with a fixed-latency divider model and hand-computed results.
module tb_fp_divider_arbiter;
   localparam int N = 2;
   localparam int W = 32;
   localparam int L = 28;

   localparam logic [31:0] F_0P25 = 32'h3E80_0000;
   localparam logic [31:0] F_1    = 32'h3F80_0000;
   localparam logic [31:0] F_2    = 32'h4000_0000;
   localparam logic [31:0] F_3    = 32'h4040_0000;
   localparam logic [31:0] F_4    = 32'h4080_0000;
   localparam logic [31:0] F_6    = 32'h40C0_0000;
   localparam logic [31:0] F_8    = 32'h4100_0000;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid, req_lock, req_grant, resp_valid;
   logic [N*W-1:0] req_a, req_b;
   logic [W-1:0]   resp_data, div_a, div_b, div_o;
   logic           quiesce, idle, div_ready, div_valid, err;
   logic           inject;

   int errors = 0;
   int checks = 0;

   logic          m_v [L];
   logic [W-1:0]  m_d [L];

   always #5 clk = ~clk;

   fp_divider_arbiter #(.NUM_REQ(N), .WIDTH(W), .DIVIDER_LATENCY(L)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_lock(req_lock),
      .req_a(req_a), .req_b(req_b), .req_grant(req_grant), .resp_valid(resp_valid),
      .resp_data(resp_data), .quiesce(quiesce), .idle(idle), .div_a(div_a),
      .div_b(div_b), .div_ready(div_ready), .div_o(div_o), .div_valid(div_valid),
      .err(err)
   );

   // Quotients for the operand pairs this bench issues; anything else yields a NaN marker.
   function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
      case ({a, b})
         {F_6, F_2}: return F_3;
         {F_8, F_2}: return F_4;
         {F_1, F_4}: return F_0P25;
         default:    return 32'h7FC0_0000;
      endcase
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < L; i++) begin
            m_v[i] <= 1'b0;
            m_d[i] <= '0;
         end
      end else begin
         m_v[0] <= div_ready;
         m_d[0] <= fdiv(div_a, div_b);
         for (int i = 1; i < L; i++) begin
            m_v[i] <= m_v[i-1];
            m_d[i] <= m_d[i-1];
         end
      end
   end

   assign div_valid = m_v[L-1] | inject;
   assign div_o     = m_d[L-1];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(negedge clk);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (idle !== 1'b1 && n < 200) begin
         next_cycle();
         #1;
         n++;
      end
      check("wait_idle", idle, 1'b1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_grant"}, req_grant, 2'b00);
      check({tag, "_resp_valid"}, resp_valid, 2'b00);
      check({tag, "_div_ready"}, div_ready, 1'b0);
      check({tag, "_idle"}, idle, 1'b1);
      check({tag, "_err"}, err, 1'b0);
   endtask

   initial begin
      logic early;
      logic bad_grant;
      logic bad_idle;

      rst = 1'b0; req_valid = '0; req_lock = '0; req_a = '0; req_b = '0;
      quiesce = 1'b0; inject = 1'b0;
      #1;
      check_reset_outputs("reset");
      repeat (3) next_cycle();
      rst = 1'b1;

      // Single requester: 6.0 / 2.0 on req 0, result 28 cycles later.
      next_cycle();
      req_valid = 2'b01; req_a[31:0] = F_6; req_b[31:0] = F_2;
      #1;
      check("t1_grant", req_grant, 2'b01);
      check("t1_div_ready", div_ready, 1'b1);
      check("t1_div_a", div_a, F_6);
      check("t1_div_b", div_b, F_2);
      check("t1_idle_busy", idle, 1'b0);
      early = 1'b0;
      for (int k = 1; k <= 29; k++) begin
         next_cycle();
         req_valid = 2'b00;
         #1;
         if (k < 28 && resp_valid != 2'b00) early = 1'b1;
         if (k == 28) begin
            check("t1_resp_valid", resp_valid, 2'b01);
            check("t1_resp_data", resp_data, F_3);
            check("t1_idle_at_resp", idle, 1'b0);
         end
         if (k == 29) check("t1_idle_after", idle, 1'b1);
      end
      check("t1_no_early_resp", early, 1'b0);

      // Two requesters streaming; pointer sits at 1 after the single issue above.
      req_a = {F_1, F_8}; req_b = {F_4, F_2};
      early = 1'b0;
      for (int i = 0; i <= 36; i++) begin
         next_cycle();
         req_valid = (i < 8) ? 2'b11 : 2'b00;
         #1;
         if (i < 8) check($sformatf("t2_grant_%0d", i), req_grant, (i % 2 == 0) ? 2'b10 : 2'b01);
         if (i >= 8 && i < 28 && resp_valid != 2'b00) early = 1'b1;
         if (i >= 28 && i < 36) begin
            check($sformatf("t2_resp_valid_%0d", i - 28), resp_valid, (i % 2 == 0) ? 2'b10 : 2'b01);
            check($sformatf("t2_resp_data_%0d", i - 28), resp_data, (i % 2 == 0) ? F_0P25 : F_4);
         end
         if (i == 36) check("t2_idle_after", idle, 1'b1);
      end
      check("t2_no_stray_resp", early, 1'b0);

      // Req 1 locks for five issues while req 0 waits; one gap cycle on release.
      for (int i = 0; i <= 6; i++) begin
         next_cycle();
         req_valid = (i < 5) ? 2'b11 : 2'b01;
         req_lock  = (i < 5) ? 2'b10 : 2'b00;
         #1;
         check($sformatf("t3_grant_%0d", i), req_grant, (i < 5) ? 2'b10 : (i == 5) ? 2'b00 : 2'b01);
      end
      next_cycle();
      req_valid = 2'b00;
      wait_idle();

      // Ten issues, then quiesce with requests still pending.
      for (int i = 0; i < 10; i++) begin
         next_cycle();
         req_valid = 2'b11;
         #1;
         check($sformatf("t4_grant_%0d", i), req_grant, (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      bad_grant = 1'b0; bad_idle = 1'b0;
      for (int i = 10; i <= 38; i++) begin
         next_cycle();
         quiesce = 1'b1;
         #1;
         if (req_grant != 2'b00 || div_ready != 1'b0) bad_grant = 1'b1;
         if (i <= 37 && idle != 1'b0) bad_idle = 1'b1;
         if (i == 37) check("t4_last_resp", resp_valid, 2'b01);
         if (i == 38) check("t4_idle_drained", idle, 1'b1);
      end
      check("t4_no_grant_quiesced", bad_grant, 1'b0);
      check("t4_busy_until_last", bad_idle, 1'b0);
      next_cycle();
      quiesce = 1'b0;
      #1;
      check("t4_drain_exit_gap", req_grant, 2'b00);
      next_cycle();
      #1;
      check("t4_resume_grant", req_grant, 2'b10);
      next_cycle();
      req_valid = 2'b00;
      wait_idle();

      // Reset ten cycles after three issues discards them.
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         req_valid = 2'b11;
         #1;
         check($sformatf("t5_grant_%0d", i), req_grant, (i == 1) ? 2'b10 : 2'b01);
      end
      next_cycle();
      req_valid = 2'b00;
      repeat (9) next_cycle();
      rst = 1'b0;
      #1;
      check_reset_outputs("t5_midreset");
      repeat (2) next_cycle();
      rst = 1'b1;
      early = 1'b0;
      for (int i = 0; i < 40; i++) begin
         next_cycle();
         #1;
         if (resp_valid != 2'b00 || idle != 1'b1) early = 1'b1;
      end
      check("t5_no_resp_after_reset", early, 1'b0);
      next_cycle();
      req_valid = 2'b11;
      #1;
      check("t5_pointer_reset", req_grant, 2'b01);
      next_cycle();
      req_valid = 2'b00;
      wait_idle();

      // Divider strobe with an empty tag pipe is never routed; with the checker it latches err.
      next_cycle();
      inject = 1'b1;
      #1;
      check("t6_inject_not_routed", resp_valid, 2'b00);
      check("t6_err_before_edge", err, 1'b0);
      next_cycle();
      inject = 1'b0;
      #1;
`ifdef FP_DIV_ARB_CHECK_EN
      check("t6_err_set", err, 1'b1);
      repeat (3) next_cycle();
      #1;
      check("t6_err_sticky", err, 1'b1);
      rst = 1'b0;
      #1;
      check("t6_err_cleared", err, 1'b0);
      next_cycle();
      rst = 1'b1;
`else
      check("t6_err_tied_off", err, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
